note_player: RTL and testbench

NOTE_PLAYER -- requirements
Module: note_player

---
 rtl/note_player_pkg.sv | 40 ++++
 rtl/note_player_rom.sv | 41 ++++
 rtl/note_player.sv | 108 ++++++++++
 tb/tb_note_player.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/note_player_pkg.sv
// Shared definitions for the note player: state encoding, default widths,
// the rest-note code and the top-octave tuning table used by the frequency ROM.
package note_player_pkg;

  localparam int BEAT_W_DEF  = 6;
  localparam int STEP_W_DEF  = 20;
  localparam int NOTE_W      = 6;
  localparam int PHASE_OUT_W = 10;

  localparam logic [NOTE_W-1:0] REST_NOTE = 6'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COUNT  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // Phase steps for the highest octave (A = 1760 Hz at 48 kHz, 20-bit phase);
  // lower octaves are obtained by right shifts.
  function automatic logic [16:0] top_octave_step(input logic [3:0] semi);
    logic [16:0] s;
    case (semi)
      4'd0:    s = 17'd38448;
      4'd1:    s = 17'd40734;
      4'd2:    s = 17'd43156;
      4'd3:    s = 17'd45722;
      4'd4:    s = 17'd48441;
      4'd5:    s = 17'd51322;
      4'd6:    s = 17'd54373;
      4'd7:    s = 17'd57607;
      4'd8:    s = 17'd61032;
      4'd9:    s = 17'd64662;
      4'd10:   s = 17'd68506;
      default: s = 17'd72580;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/note_player_rom.sv
// Frequency ROM: note index in, phase-accumulator step out, one registered
// cycle of latency. Note 1 is the lowest A; each 12 notes up doubles the step.
module frequency_rom
  import note_player_pkg::*;
#(
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NOTE_W-1:0] note_i,
  output logic [STEP_W-1:0] step_o
);

  logic [NOTE_W-1:0] note_m1;
  logic [3:0]        semi;
  logic [2:0]        octave;
  logic [STEP_W-1:0] step_d;
  logic [STEP_W-1:0] step_q;

  always_comb begin
    note_m1 = note_i - 6'd1;
    semi    = 4'(note_m1 % 6'd12);
    octave  = 3'(note_m1 / 6'd12);
    if (note_i == REST_NOTE) begin
      step_d = '0;
    end else begin
      step_d = STEP_W'(top_octave_step(semi)) >> (3'd5 - octave);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_q <= '0;
    end else begin
      step_q <= step_d;
    end
  end

  assign step_o = step_q;

endmodule

// File: rtl/note_player.sv
// Plays one song entry: counts its duration in beats, drives a phase
// accumulator for a downstream sine lookup, and pulses when the entry ends.
module note_player
  import note_player_pkg::*;
#(
  parameter int BEAT_W = BEAT_W_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   play_enable,
  input  logic                   load_new_note,
  input  logic [NOTE_W-1:0]      note,
  input  logic [BEAT_W-1:0]      duration,
  input  logic                   waiting,
  input  logic                   beat,
  input  logic                   generate_next_sample,
  output logic                   note_done,
  output logic                   done_waiting,
  output logic [PHASE_OUT_W-1:0] sample_phase,
  output logic                   busy,
  output state_e                 dbg_state_o
);

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] count_q, count_d;
  logic              waiting_q, waiting_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [STEP_W-1:0] phase_q, phase_d;
  logic [STEP_W-1:0] rom_step;
  logic              beat_en;

  // The ROM samples the note input every cycle, so its output during LOAD
  // reflects the note presented with the load strobe.
  frequency_rom #(.STEP_W(STEP_W)) u_rom (
    .clk    (clk),
    .reset  (reset),
    .note_i (note),
    .step_o (rom_step)
  );

  assign beat_en = beat && play_enable;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      waiting_q <= 1'b0;
      step_q    <= '0;
      phase_q   <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      waiting_q <= waiting_d;
      step_q    <= step_d;
      phase_q   <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   state_d = ST_IDLE;
      ST_LOAD:   state_d = ST_COUNT;
      ST_COUNT: begin
        if (count_q == '0) begin
          state_d = ST_FINISH;
        end else if (beat_en && count_q == BEAT_W'(1)) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // A new entry always wins, including over the terminal beat.
    if (load_new_note) begin
      state_d = ST_LOAD;
    end
  end

  always_comb begin
    count_d   = count_q;
    waiting_d = waiting_q;
    step_d    = step_q;
    phase_d   = phase_q;
    if (load_new_note) begin
      count_d   = duration;
      waiting_d = waiting;
    end else if (state_q == ST_COUNT && beat_en && count_q != '0) begin
      count_d = count_q - BEAT_W'(1);
    end
    if (state_q == ST_LOAD && !load_new_note && !waiting_q) begin
      step_d = rom_step;
    end
    if (generate_next_sample && play_enable) begin
      phase_d = phase_q + step_q;
    end
  end

  always_comb begin
    note_done    = (state_q == ST_FINISH) && !waiting_q;
    done_waiting = (state_q == ST_FINISH) && waiting_q;
    busy         = (state_q == ST_LOAD) || (state_q == ST_COUNT);
    sample_phase = phase_q[STEP_W-1 -: PHASE_OUT_W];
    dbg_state_o  = state_q;
  end

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player: directed table, hand-written corner sequences and
// random traffic, all scored against an entry-level model of the player.
module tb_note_player;
  import note_player_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       play_enable = 1'b0;
  logic       load_new_note = 1'b0;
  logic [5:0] note = '0;
  logic [5:0] duration = '0;
  logic       waiting = 1'b0;
  logic       beat = 1'b0;
  logic       generate_next_sample = 1'b0;
  logic       note_done, done_waiting, busy;
  logic [9:0] sample_phase;
  state_e     dbg_state;

  note_player dut (
    .clk                  (clk),
    .reset                (reset),
    .play_enable          (play_enable),
    .load_new_note        (load_new_note),
    .note                 (note),
    .duration             (duration),
    .waiting              (waiting),
    .beat                 (beat),
    .generate_next_sample (generate_next_sample),
    .note_done            (note_done),
    .done_waiting         (done_waiting),
    .sample_phase         (sample_phase),
    .busy                 (busy),
    .dbg_state_o          (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int ref_base [12] = '{38448, 40734, 43156, 45722, 48441, 51322,
                        54373, 57607, 61032, 64662, 68506, 72580};

  function automatic logic [19:0] ref_step(input int n);
    if (n == 0) return 20'd0;
    return 20'(ref_base[(n - 1) % 12] >> (5 - (n - 1) / 12));
  endfunction

  int          m_age;     // -1 no entry, 0 just loaded, 1 counting
  int          m_rem;
  int          m_note;
  bit          m_wait;
  bit          m_fin;
  logic [19:0] m_step;
  logic [19:0] m_phase;

  task automatic model_reset();
    m_age = -1; m_rem = 0; m_note = 0; m_wait = 0; m_fin = 0;
    m_step = '0; m_phase = '0;
  endtask

  task automatic model_edge(input bit ld, input int nt, input int du,
                            input bit wt, input bit bt, input bit gn, input bit en);
    m_fin = 0;
    if (gn && en) m_phase = m_phase + m_step;
    if (ld) begin
      m_age = 0; m_rem = du; m_wait = wt; m_note = nt;
    end else if (m_age == 0) begin
      m_age = 1;
      if (!m_wait) m_step = ref_step(m_note);
    end else if (m_age == 1) begin
      if (m_rem == 0) m_fin = 1;
      else if (bt && en) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) m_fin = 1;
      end
      if (m_fin) m_age = -1;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [12:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int nd_cnt = 0;
  int dw_cnt = 0;

  task automatic check_val(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs (called just after a falling edge), advance the
  // model at the rising edge and compare all outputs at the next falling edge.
  task automatic apply(input bit ld, input int nt, input int du, input bit wt,
                       input bit bt, input bit gn, input bit en);
    logic [12:0] exp, obs;
    load_new_note = ld; note = 6'(nt); duration = 6'(du); waiting = wt;
    beat = bt; generate_next_sample = gn; play_enable = en;
    @(posedge clk);
    model_edge(ld, nt, du, wt, bt, gn, en);
    exp_q.push_back({m_fin & ~m_wait, m_fin & m_wait, m_age >= 0, m_phase[19:10]});
    @(negedge clk);
    obs = {note_done, done_waiting, busy, sample_phase};
    exp = exp_q.pop_front();
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL cycle: got done=%b dw=%b busy=%b ph=%0d expected done=%b dw=%b busy=%b ph=%0d at %0t",
               obs[12], obs[11], obs[10], obs[9:0], exp[12], exp[11], exp[10], exp[9:0], $time);
    end
    nd_cnt += int'(note_done);
    dw_cnt += int'(done_waiting);
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0, 1, en);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_done"}, int'(note_done), 0);
    check_val({tag, "_dw"}, int'(done_waiting), 0);
    check_val({tag, "_busy"}, int'(busy), 0);
    check_val({tag, "_phase"}, int'(sample_phase), 0);
  endtask

  typedef struct {
    bit ld; int nt; int du; bit wt; bit bt;
    bit x_done; bit x_dw; bit x_busy;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int ph0;
    // load note1 dur3, three beats -> note_done one cycle after the 3rd beat
    tbl[0]  = '{1, 1, 3, 0, 0, 0, 0, 1};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 1};
    tbl[2]  = '{0, 0, 0, 0, 1, 0, 0, 1};
    tbl[3]  = '{0, 0, 0, 0, 1, 0, 0, 1};
    tbl[4]  = '{0, 0, 0, 0, 1, 1, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    // duration 0 -> done on the 3rd cycle after the strobe, no beat
    tbl[6]  = '{1, 25, 0, 0, 0, 0, 0, 1};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 1};
    tbl[8]  = '{0, 0, 0, 0, 0, 1, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    // waiting entry keeps the previous step, ends with done_waiting
    tbl[10] = '{1, 50, 2, 1, 0, 0, 0, 1};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 1};
    tbl[12] = '{0, 0, 0, 0, 1, 0, 0, 1};
    tbl[13] = '{0, 0, 0, 0, 1, 0, 1, 0};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0};

    // ---- reset ----
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);

    // ---- table-driven vectors ----
    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].ld, tbl[i].nt, tbl[i].du, tbl[i].wt, tbl[i].bt, 1, 1);
      check_val($sformatf("tbl%0d_done", i), int'(note_done), int'(tbl[i].x_done));
      check_val($sformatf("tbl%0d_dw", i), int'(done_waiting), int'(tbl[i].x_dw));
      check_val($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].x_busy));
    end
    // the waiting entry must not have replaced note 25's step
    check_val("wait_step_kept", int'(dut.step_q), int'(ref_step(25)));

    // ---- play_enable drop during COUNT ----
    nd_cnt = 0;
    apply(1, 20, 4, 0, 0, 1, 1);
    idle(1, 1);
    apply(0, 0, 0, 0, 1, 1, 1);
    apply(0, 0, 0, 0, 1, 1, 1);
    ph0 = int'(sample_phase);
    for (int i = 0; i < 10; i++) begin
      apply(0, 0, 0, 0, 1, 1, 0);
      check_val("disabled_phase", int'(sample_phase), ph0);
    end
    check_val("disabled_no_done", nd_cnt, 0);
    apply(0, 0, 0, 0, 1, 1, 1);
    apply(0, 0, 0, 0, 1, 1, 1);
    idle(2, 1);
    check_val("enable_done_count", nd_cnt, 1);

    // ---- reload mid-count, then reload on the terminal beat ----
    nd_cnt = 0;
    apply(1, 30, 5, 0, 0, 1, 1);
    idle(1, 1);
    repeat (3) apply(0, 0, 0, 0, 1, 1, 1);
    apply(1, 31, 2, 0, 0, 1, 1);
    idle(1, 1);
    repeat (2) apply(0, 0, 0, 0, 1, 1, 1);
    idle(2, 1);
    check_val("reload_single_done", nd_cnt, 1);
    nd_cnt = 0;
    apply(1, 40, 2, 0, 0, 1, 1);
    idle(1, 1);
    apply(0, 0, 0, 0, 1, 1, 1);
    apply(1, 41, 3, 0, 1, 1, 1);
    idle(2, 1);
    check_val("terminal_reload_no_done", nd_cnt, 0);
    repeat (3) apply(0, 0, 0, 0, 1, 1, 1);
    idle(2, 1);
    check_val("terminal_reload_later_done", nd_cnt, 1);

    // ---- rest note: step 0, phase holds ----
    apply(1, 0, 1, 0, 0, 1, 1);
    idle(1, 1);
    ph0 = int'(sample_phase);
    idle(3, 1);
    check_val("rest_phase_hold", int'(sample_phase), ph0);
    apply(0, 0, 0, 0, 1, 1, 1);
    idle(2, 1);

    // ---- reset mid-COUNT ----
    nd_cnt = 0; dw_cnt = 0;
    apply(1, 45, 3, 0, 0, 1, 1);
    idle(1, 1);
    apply(0, 0, 0, 0, 1, 1, 1);
    #2 reset = 1'b0;
    #1 check_reset_outputs("midreset");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (4) apply(0, 0, 0, 0, 1, 1, 1);
    check_val("midreset_no_done", nd_cnt + dw_cnt, 0);

    // ---- random traffic ----
    for (int i = 0; i < 600; i++) begin
      apply($urandom_range(0, 15) == 0, int'($urandom_range(0, 63)),
            int'($urandom_range(0, 6)), $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
